pipe_skid_buffer: RTL and testbench
===================================

PIPE_SKID_BUFFER -- requirements
Module: pipe_skid_buffer

Interface
REQ-001 SHALL provide parameter WIDTH, default 32, payload width in bits.
REQ-002 SHALL provide port clk  input  1  single rising-edge clock for all state.
REQ-003 SHALL provide port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL provide port flush  input  1  synchronous discard of all held entries.
REQ-005 SHALL provide port in_valid  input  1  upstream presents payload.
REQ-006 SHALL provide port in_data  input  WIDTH  upstream payload.
REQ-007 SHALL provide port in_ready  output  1  block accepts payload this cycle.
REQ-008 SHALL provide port out_valid  output  1  out_data holds a valid entry.
REQ-009 SHALL provide port out_data  output  WIDTH  oldest held payload.
REQ-010 SHALL provide port out_ready  input  1  downstream consumes this cycle.
REQ-011 SHALL provide port occupancy  output  2  entries held, 0..2.

Function
REQ-012 SHALL hold two WIDTH-bit registers, MAIN (drives out_data) and SKID, plus a state register EMPTY/ONE/FULL, all updated only on the rising edge of clk.
REQ-013 SHALL define push = in_valid & in_ready and pop = out_valid & out_ready.
REQ-014 SHALL drive in_ready = (state != FULL), out_valid = (state != EMPTY), and occupancy = 0/1/2 for EMPTY/ONE/FULL, each decoded from registered state only, with no combinational path from in_valid or out_ready.
REQ-015 SHALL transition from EMPTY on push to ONE, loading MAIN <= in_data; with no push it stays EMPTY.
REQ-016 SHALL handle ONE as follows: push&pop -> ONE, MAIN <= in_data; push only -> FULL, SKID <= in_data; pop only -> EMPTY; neither -> ONE.
REQ-017 SHALL handle FULL as follows: pop -> ONE, MAIN <= SKID; no pop -> FULL; push is impossible because in_ready = 0.
REQ-018 SHALL give a latency of exactly one cycle from push into EMPTY to out_valid = 1, and SHALL sustain one transfer per cycle when out_ready is held high.
REQ-019 SHALL ignore in_valid and in_data while in_ready = 0; upstream holds the payload.
REQ-020 SHALL keep out_data and out_valid stable while out_valid = 1 and out_ready = 0.
REQ-021 SHALL preserve order: payloads leave in exact push order and none is duplicated or dropped.
REQ-022 SHALL, on flush = 1 at a clock edge, force state to EMPTY regardless of in_valid or out_ready in that cycle; a same-cycle push is discarded and flush has priority over every transition.
REQ-023 SHALL leave MAIN and SKID contents unchanged on flush; only state is cleared.

Reset
REQ-024 SHALL, while reset = 0, immediately and without waiting for clk force state = EMPTY and MAIN = SKID = 0, giving in_ready = 1, out_valid = 0, out_data = 0, occupancy = 0.
REQ-025 SHALL, on reset asserted mid-operation, abandon all held entries with no partial transfer.
REQ-026 SHALL accept a push on the first rising edge of clk after reset deasserts.

Verification
REQ-027 SHALL cover single pass: push 0x1234_5678 with out_ready = 1 -> out_valid = 1 and out_data = 0x1234_5678 on the next cycle, then occupancy 0 the cycle after.
REQ-028 SHALL cover fill and stall: out_ready = 0, push 0xA then 0xB -> occupancy = 2, in_ready = 0; 0xC is held on in_data and not accepted; out_data stays 0xA.
REQ-029 SHALL cover drain from FULL: from the REQ-028 state, raise out_ready -> outputs are 0xA, 0xB, then 0xC (accepted once in_ready = 1), in order, with no gaps beyond one cycle.
REQ-030 SHALL cover streaming: 100 consecutive pushes of an incrementing count with out_ready = 1 -> 100 pops, in order, one per cycle after the first.
REQ-031 SHALL cover flush: in FULL, assert flush together with in_valid = 1 and out_ready = 1 -> next cycle occupancy = 0, out_valid = 0, in_ready = 1, and the flushed payloads never appear.
REQ-032 SHALL cover async reset: drop reset between clock edges while state is ONE -> out_valid = 0 and out_data = 0 before the next edge.

Source files
------------

// File: rtl/pipe_skid_buffer.sv
// Two-entry skid buffer: MAIN feeds the output, SKID absorbs the one payload
// that arrives while the downstream stalls. All handshake outputs decode from state.
module pipe_skid_buffer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [1:0]       occupancy
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_main;
  logic [WIDTH-1:0] r_skid;
  logic             w_push;
  logic             w_pop;

  assign in_ready  = (r_state != FULL);
  assign out_valid = (r_state != EMPTY);
  assign occupancy = logic'(r_state == ONE) ? 2'd1 :
                     logic'(r_state == FULL) ? 2'd2 : 2'd0;
  assign out_data  = r_main;

  assign w_push = in_valid & in_ready;
  assign w_pop  = out_valid & out_ready;

  // Flush clears only the state; payload registers keep their stale contents.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= EMPTY;
      r_main  <= '0;
      r_skid  <= '0;
    end else if (flush) begin
      r_state <= EMPTY;
    end else begin
      unique case (r_state)
        EMPTY: begin
          if (w_push) begin
            r_state <= ONE;
            r_main  <= in_data;
          end
        end
        ONE: begin
          if (w_push && w_pop) begin
            r_main <= in_data;
          end else if (w_push) begin
            r_state <= FULL;
            r_skid  <= in_data;
          end else if (w_pop) begin
            r_state <= EMPTY;
          end
        end
        FULL: begin
          if (w_pop) begin
            r_state <= ONE;
            r_main  <= r_skid;
          end
        end
        default: r_state <= EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_skid_buffer.sv
// Scoreboard bench for pipe_skid_buffer: a queue model predicts handshakes,
// occupancy and the order of every payload leaving the buffer.
module tb_pipe_skid_buffer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_ready = 1'b0;
  logic [1:0]  occupancy;

  int          total = 0;
  int          bad = 0;
  int          pop_cnt = 0;
  logic [31:0] sb_q[$];

  pipe_skid_buffer #(.WIDTH(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model runs on the falling edge, predicting what the next rising edge does.
  always @(negedge clk) begin
    logic [31:0] exp_d;
    int sz;
    if (!reset) sb_q.delete();
    sz = sb_q.size();
    chk("occupancy", 32'(occupancy), 32'(sz));
    chk("in_ready", 32'(in_ready), 32'(sz < 2));
    chk("out_valid", 32'(out_valid), 32'(sz > 0));
    if (reset) begin
      if (flush) begin
        sb_q.delete();
      end else begin
        if (out_ready && sz > 0) begin
          exp_d = sb_q.pop_front();
          chk("pop_data", out_data, exp_d);
          pop_cnt++;
        end
        if (in_valid && sz < 2) sb_q.push_back(in_data);
      end
    end
  end

  initial begin
    int pops_before;
    #1 reset = 1'b0;
    tick();
    tick();
    chk("rst_occ", 32'(occupancy), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    reset = 1'b1;

    // Single pass, pushed on the first edge after reset release
    in_valid = 1'b1; in_data = 32'h1234_5678; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("single_valid", 32'(out_valid), 32'd1);
    chk("single_data", out_data, 32'h1234_5678);
    tick();
    chk("single_occ0", 32'(occupancy), 32'd0);

    // Fill and stall
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'hA;
    tick();
    in_data = 32'hB;
    tick();
    chk("fill_occ", 32'(occupancy), 32'd2);
    chk("fill_in_ready", 32'(in_ready), 32'd0);
    chk("fill_data", out_data, 32'hA);
    in_data = 32'hC;
    tick();
    tick();
    chk("stall_occ", 32'(occupancy), 32'd2);
    chk("stall_data", out_data, 32'hA);
    chk("stall_valid", 32'(out_valid), 32'd1);

    // Drain from FULL
    out_ready = 1'b1;
    tick();
    chk("drain_b", out_data, 32'hB);
    chk("drain_in_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    chk("drain_c", out_data, 32'hC);
    tick();
    chk("drain_occ0", 32'(occupancy), 32'd0);

    // Streaming
    pops_before = pop_cnt;
    for (int i = 0; i < 100; i++) begin
      in_valid = 1'b1; in_data = 32'h100 + 32'(i);
      tick();
      chk("stream_occ", 32'(occupancy), 32'd1);
    end
    in_valid = 1'b0;
    tick();
    tick();
    chk("stream_pops", 32'(pop_cnt - pops_before), 32'd100);

    // Flush while FULL with a simultaneous push and pop request
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'hD1;
    tick();
    in_data = 32'hD2;
    tick();
    chk("pre_flush_occ", 32'(occupancy), 32'd2);
    flush = 1'b1; in_data = 32'hEE; out_ready = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_occ", 32'(occupancy), 32'd0);
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    chk("flush_in_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b1; in_data = 32'hF0;
    tick();
    in_valid = 1'b0;
    chk("post_flush_data", out_data, 32'hF0);
    tick();

    // Asynchronous reset while ONE
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'h55;
    tick();
    in_valid = 1'b0;
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    #1 reset = 1'b0;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_out_data", out_data, 32'd0);
    chk("arst_occ", 32'(occupancy), 32'd0);
    chk("arst_in_ready", 32'(in_ready), 32'd1);
    tick();
    reset = 1'b1;
    in_valid = 1'b1; in_data = 32'h77; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("post_rst_data", out_data, 32'h77);
    tick();
    tick();
    chk("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
